uart_tx: RTL

Serial transmitter for the UART block and the counterpart of the UART_RX receive path. It accepts a parallel data word with a valid strobe and frames it as start bit, data bits LSB-first, optional parity bit and stop bit. It drives the idle-high serial line `tx_out`. Each bit is held for CLKS_PER_BIT clocks, derived from an internal prescale counter.

---
 rtl/uart_tx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter.
// Frames a parallel word as: start bit (0), DATA_WIDTH data bits LSB-first,
// an optional parity bit, and a stop bit (1). Each bit lasts CLKS_PER_BIT
// clocks. The line idles high.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   p_data     parallel word to send
//   data_valid p_data is offered; taken when busy is low on a clock edge
//   par_en     1 = append a parity bit after the data bits
//   par_typ    0 = even parity, 1 = odd parity
//   tx_out     registered serial output, idle high
//   busy       registered; high = a new word will not be taken
//
// Optional build macro UART_TX_HOLD_REG_EN adds a one-entry holding register
// so that a second word can be taken during a frame and sent with no idle gap.
// In that build busy means "holding register full".
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | line high, waiting for a word
// START  | start bit (0)
// DATA   | data bits, shift_q[0] on the line, LSB first
// PARITY | latched parity bit
// STOP   | stop bit (1)

module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  bit_end;

`ifdef UART_TX_HOLD_REG_EN
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_pe_q, hold_pe_d;
    logic                  hold_pt_q, hold_pt_d;
    logic                  hold_full_q, hold_full_d;
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        busy_d    = busy_q;
`ifdef UART_TX_HOLD_REG_EN
        hold_data_d = hold_data_q;
        hold_pe_d   = hold_pe_q;
        hold_pt_d   = hold_pt_q;
        hold_full_d = hold_full_q;
`endif

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
`ifdef UART_TX_HOLD_REG_EN
                // A word captured on the final stop edge is still pending here.
                if (hold_full_q) begin
                    shift_d     = hold_data_q;
                    par_en_d    = hold_pe_q;
                    par_bit_d   = (^hold_data_q) ^ hold_pt_q;
                    hold_full_d = 1'b0;
                    bit_d       = '0;
                    cnt_d       = '0;
                    state_d     = START;
                end else if (data_valid) begin
`else
                if (data_valid && !busy_q) begin
                    busy_d    = 1'b1;
`endif
                    shift_d   = p_data;
                    par_en_d  = par_en;
                    par_bit_d = (^p_data) ^ par_typ;
                    bit_d     = '0;
                    cnt_d     = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
`ifdef UART_TX_HOLD_REG_EN
                    if (hold_full_q) begin
                        shift_d     = hold_data_q;
                        par_en_d    = hold_pe_q;
                        par_bit_d   = (^hold_data_q) ^ hold_pt_q;
                        hold_full_d = 1'b0;
                        bit_d       = '0;
                        state_d     = START;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    busy_d  = 1'b0;
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_TX_HOLD_REG_EN
        // Capture only while a frame is running; in IDLE the word bypasses.
        if (state_q != IDLE && data_valid && !hold_full_q) begin
            hold_data_d = p_data;
            hold_pe_d   = par_en;
            hold_pt_d   = par_typ;
            hold_full_d = 1'b1;
        end
        busy_d = hold_full_d;
`endif

        // The line level is registered, so derive it from the next state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_TX_HOLD_REG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_data_q <= '0;
            hold_pe_q   <= 1'b0;
            hold_pt_q   <= 1'b0;
            hold_full_q <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_pe_q   <= hold_pe_d;
            hold_pt_q   <= hold_pt_d;
            hold_full_q <= hold_full_d;
        end
    end
`endif

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule
